// File: rtl/datapath_seq_if.sv
// Memory bus between datapath_seq and its memory.
// Request is held until acked; ack completes the transfer.
interface datapath_seq_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic              o_mem_req;
  logic              o_mem_we;
  logic [AWIDTH-1:0] o_mem_addr;
  logic [DWIDTH-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DWIDTH-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/datapath_seq.sv
// Multi-cycle accumulator machine: fetch, decode,
// indirect and execute over a req/ack memory bus.
module datapath_seq #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              i_clr_reg,
  input  logic              i_run,
  datapath_seq_if.master    mem,
  output logic [DWIDTH-1:0] o_ac,
  output logic [DWIDTH-1:0] o_ir,
  output logic [AWIDTH-1:0] o_pc,
  output logic              o_e,
  output logic [2:0]        o_state,
  output logic              o_instr_done,
  output logic              o_halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_INDIR  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e            state_q;
  logic [DWIDTH-1:0] ac_q;
  logic [DWIDTH-1:0] dr_q;
  logic [DWIDTH-1:0] ir_q;
  logic [AWIDTH-1:0] ar_q;
  logic [AWIDTH-1:0] pc_q;
  logic              e_q;
  logic [1:0]        sc_q;
  logic              req_q;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              done_q;
  logic              halted_q;

  logic              ir_i;
  logic [2:0]        op;
  logic [AWIDTH-1:0] ir_addr;
  logic [11:0]       rb;
  logic              ack;
  logic [DWIDTH-1:0] rdata;
  logic [AWIDTH-1:0] pc_inc_d;
  logic [AWIDTH-1:0] ar_inc_d;
  logic [DWIDTH:0]   sum_d;
  state_e            nxt_d;
  logic [DWIDTH-1:0] rr_ac_d;
  logic              rr_e_d;
  logic              rr_skip_d;

  assign ir_i     = ir_q[DWIDTH-1];
  assign op       = ir_q[DWIDTH-2:DWIDTH-4];
  assign ir_addr  = ir_q[AWIDTH-1:0];
  assign rb       = ir_q[11:0];
  assign ack      = mem.i_mem_ack;
  assign rdata    = mem.i_mem_rdata;
  assign pc_inc_d = pc_q + AWIDTH'(1);
  assign ar_inc_d = ar_q + AWIDTH'(1);
  assign sum_d    = {1'b0, ac_q} + {1'b0, rdata};
  assign nxt_d    = i_run ? S_FETCH : S_IDLE;

  // Register-reference result: clear, complement,
  // rotate, increment; skips test pre-update AC/E.
  always_comb begin
    rr_ac_d = ac_q;
    rr_e_d  = e_q;
    if (rb[11]) rr_ac_d = '0;
    if (rb[10]) rr_e_d = 1'b0;
    if (rb[9])  rr_ac_d = ~rr_ac_d;
    if (rb[8])  rr_e_d = ~rr_e_d;
    if (rb[7] && !rb[6])
      {rr_ac_d, rr_e_d} = {rr_e_d, rr_ac_d};
    if (rb[6] && !rb[7])
      {rr_e_d, rr_ac_d} = {rr_ac_d, rr_e_d};
    if (rb[5]) rr_ac_d = rr_ac_d + DWIDTH'(1);
    rr_skip_d = (rb[4] && !ac_q[DWIDTH-1])
             || (rb[3] &&  ac_q[DWIDTH-1])
             || (rb[2] &&  (ac_q == '0))
             || (rb[1] && !e_q);
  end

  // Control FSM and all architectural registers.
  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) begin
      state_q  <= S_IDLE;
      ac_q     <= '0;
      dr_q     <= '0;
      ir_q     <= '0;
      ar_q     <= '0;
      pc_q     <= '0;
      e_q      <= 1'b0;
      sc_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (ack) begin
            req_q   <= 1'b0;
            ir_q    <= rdata;
            pc_q    <= pc_inc_d;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ar_q <= ir_addr;
          sc_q <= '0;
          if (op != 3'd7 && ir_i)
            state_q <= S_INDIR;
          else
            state_q <= S_EXEC;
        end
        S_INDIR: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= ar_q;
          end else if (ack) begin
            req_q   <= 1'b0;
            ar_q    <= rdata[AWIDTH-1:0];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (op)
            3'd0, 3'd1, 3'd2: begin
              if (!req_q) begin
                req_q  <= 1'b1;
                we_q   <= 1'b0;
                addr_q <= ar_q;
              end else if (ack) begin
                req_q <= 1'b0;
                if (op == 3'd0)
                  ac_q <= ac_q & rdata;
                else if (op == 3'd1)
                  {e_q, ac_q} <= sum_d;
                else
                  ac_q <= rdata;
                done_q  <= 1'b1;
                state_q <= nxt_d;
              end
            end
            3'd3: begin
              if (!req_q) begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= ar_q;
                wdata_q <= ac_q;
              end else if (ack) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                done_q  <= 1'b1;
                state_q <= nxt_d;
              end
            end
            3'd4: begin
              pc_q    <= ar_q;
              done_q  <= 1'b1;
              state_q <= nxt_d;
            end
            3'd5: begin
              if (!req_q) begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= ar_q;
                wdata_q <= DWIDTH'(pc_q);
              end else if (ack) begin
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                pc_q    <= ar_inc_d;
                done_q  <= 1'b1;
                state_q <= nxt_d;
              end
            end
            3'd6: begin
              unique case (sc_q)
                2'd0: begin
                  if (!req_q) begin
                    req_q  <= 1'b1;
                    we_q   <= 1'b0;
                    addr_q <= ar_q;
                  end else if (ack) begin
                    req_q <= 1'b0;
                    dr_q  <= rdata;
                    sc_q  <= 2'd1;
                  end
                end
                2'd1: begin
                  dr_q <= dr_q + DWIDTH'(1);
                  sc_q <= 2'd2;
                end
                2'd2: begin
                  if (!req_q) begin
                    req_q   <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= ar_q;
                    wdata_q <= dr_q;
                  end else if (ack) begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                    if (dr_q == '0) pc_q <= pc_inc_d;
                    sc_q    <= '0;
                    done_q  <= 1'b1;
                    state_q <= nxt_d;
                  end
                end
                default: sc_q <= '0;
              endcase
            end
            3'd7: begin
              done_q <= 1'b1;
              if (ir_i) begin
                state_q <= nxt_d;
              end else begin
                ac_q <= rr_ac_d;
                e_q  <= rr_e_d;
                if (rr_skip_d) pc_q <= pc_inc_d;
                if (rb[0]) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
                end else begin
                  state_q <= nxt_d;
                end
              end
            end
          endcase
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;

  assign o_ac         = ac_q;
  assign o_ir         = ir_q;
  assign o_pc         = pc_q;
  assign o_e          = e_q;
  assign o_state      = state_q;
  assign o_instr_done = done_q;
  assign o_halted     = halted_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed program run against datapath_seq with a
// behavioural memory that acks after a set delay.
module tb_datapath_seq;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  logic run;
  always #5 clk = ~clk;

  datapath_seq_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();

  logic [DW-1:0] ac;
  logic [DW-1:0] ir;
  logic [AW-1:0] pc;
  logic          e;
  logic [2:0]    st;
  logic          done;
  logic          halted;

  datapath_seq #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk          (clk),
    .i_clr_reg    (rst),
    .i_run        (run),
    .mem          (bus),
    .o_ac         (ac),
    .o_ir         (ir),
    .o_pc         (pc),
    .o_e          (e),
    .o_state      (st),
    .o_instr_done (done),
    .o_halted     (halted)
  );

  logic [15:0] mem [0:4095];
  logic        resp_ack;
  logic        force_ack;
  logic [15:0] rdata_r;
  int          dly;
  bit          hold_wr;
  int          cnt;
  int          stab_err;
  int          ndone = 0;
  logic [AW-1:0] l_addr;
  logic          l_we;
  logic [DW-1:0] l_wdata;

  int checks;
  int errors;

  assign bus.i_mem_ack   = resp_ack | force_ack;
  assign bus.i_mem_rdata = rdata_r;

  always @(posedge clk) if (done) ndone <= ndone + 1;

  // memory image and responder
  initial begin
    resp_ack = 1'b0;
    rdata_r  = '0;
    cnt      = 0;
    stab_err = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h3150;
    mem[12'h001] = 16'h2100;
    mem[12'h002] = 16'h2101;
    mem[12'h003] = 16'h1102;
    mem[12'h004] = 16'h6103;
    mem[12'h005] = 16'h7001;
    mem[12'h006] = 16'h6104;
    mem[12'h007] = 16'hA110;
    mem[12'h008] = 16'h7A20;
    mem[12'h009] = 16'h7040;
    mem[12'h00A] = 16'h7080;
    mem[12'h00B] = 16'h7404;
    mem[12'h00C] = 16'h7001;
    mem[12'h00D] = 16'h40F0;
    mem[12'h0F0] = 16'h2100;
    mem[12'h0F1] = 16'h5130;
    mem[12'h131] = 16'h3140;
    mem[12'h132] = 16'hF000;
    mem[12'h133] = 16'h4FFF;
    mem[12'hFFF] = 16'h5160;
    mem[12'h161] = 16'h7001;
    mem[12'h100] = 16'h1234;
    mem[12'h101] = 16'hFFFF;
    mem[12'h102] = 16'h0001;
    mem[12'h103] = 16'hFFFF;
    mem[12'h104] = 16'h0003;
    mem[12'h110] = 16'h0120;
    mem[12'h120] = 16'h0077;
    mem[12'h150] = 16'hDEAD;
    mem[12'h160] = 16'hBEEF;
    forever begin
      @(negedge clk);
      if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (bus.o_mem_req) begin
        if (cnt == 0) begin
          l_addr  = bus.o_mem_addr;
          l_we    = bus.o_mem_we;
          l_wdata = bus.o_mem_wdata;
        end else if (l_addr !== bus.o_mem_addr ||
                     l_we !== bus.o_mem_we ||
                     l_wdata !== bus.o_mem_wdata) begin
          stab_err++;
        end
        if (cnt >= dly && !(hold_wr && bus.o_mem_we)) begin
          resp_ack = 1'b1;
          if (bus.o_mem_we)
            mem[bus.o_mem_addr] = bus.o_mem_wdata;
          else
            rdata_r = mem[bus.o_mem_addr];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic exec1();
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    wait_done();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int nreq;
    bit seen;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    run       = 1'b0;
    force_ack = 1'b0;
    dly       = 0;
    hold_wr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_ac", 32'(ac), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // STA write left pending, then reset mid-handshake
    hold_wr = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_mem_req && bus.o_mem_we) seen = 1'b1;
    end
    chk("sta_req_seen", 32'(seen), 32'd1);
    chk("sta_addr", 32'(bus.o_mem_addr), 32'h150);
    repeat (2) @(negedge clk);
    chk("sta_held", 32'(bus.o_mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("clr_req", 32'(bus.o_mem_req), 32'd0);
    chk("clr_we", 32'(bus.o_mem_we), 32'd0);
    chk("clr_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("clr_state", 32'(st), 32'd0);
    chk("clr_ir", 32'(ir), 32'd0);
    chk("clr_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_wr = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_state", 32'(st), 32'd0);
    chk("late_ack_req", 32'(bus.o_mem_req), 32'd0);
    chk("late_ack_mem", 32'(mem[12'h150]), 32'hDEAD);

    n0 = ndone;
    exec1();
    chk("sta_mem", 32'(mem[12'h150]), 32'h0000);
    chk("sta_pc", 32'(pc), 32'h001);
    exec1();
    chk("lda_ac", 32'(ac), 32'h1234);
    chk("lda_pc", 32'(pc), 32'h002);
    chk("lda_ndone", 32'(ndone - n0), 32'd2);
    chk("lda_idle", 32'(st), 32'd0);
    chk("lda_done_low", 32'(done), 32'd0);
    exec1();
    exec1();
    chk("add_ac", 32'(ac), 32'h0000);
    chk("add_e", 32'(e), 32'd1);
    exec1();
    chk("isz_wrap_mem", 32'(mem[12'h103]), 32'h0000);
    chk("isz_wrap_pc", 32'(pc), 32'h006);
    exec1();
    chk("isz_mem", 32'(mem[12'h104]), 32'h0004);
    chk("isz_pc", 32'(pc), 32'h007);
    dly = 3;
    exec1();
    dly = 0;
    chk("ind_ac", 32'(ac), 32'h0077);
    chk("ind_stable", 32'(stab_err), 32'd0);
    chk("ind_pc", 32'(pc), 32'h008);
    exec1();
    chk("rr_cla_cma_inc", 32'(ac), 32'h0000);
    chk("rr_e_kept", 32'(e), 32'd1);
    exec1();
    chk("cil_ac", 32'(ac), 32'h0001);
    chk("cil_e", 32'(e), 32'd0);
    exec1();
    chk("cir_ac", 32'(ac), 32'h0000);
    chk("cir_e", 32'(e), 32'd1);
    exec1();
    chk("sza_pc", 32'(pc), 32'h00D);
    chk("cle_e", 32'(e), 32'd0);
    exec1();
    chk("bun_pc", 32'(pc), 32'h0F0);
    exec1();
    exec1();
    chk("bsa_mem", 32'(mem[12'h130]), 32'h00F2);
    chk("bsa_pc", 32'(pc), 32'h131);
    exec1();
    chk("sta2_mem", 32'(mem[12'h140]), 32'h1234);
    exec1();
    chk("io_pc", 32'(pc), 32'h133);
    chk("io_ac", 32'(ac), 32'h1234);
    exec1();
    chk("bun_fff", 32'(pc), 32'hFFF);
    exec1();
    chk("wrap_mem", 32'(mem[12'h160]), 32'h0000);
    chk("wrap_pc", 32'(pc), 32'h161);
    exec1();
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_state", 32'(st), 32'd5);
    run = 1'b1;
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_mem_req) nreq++;
    end
    run = 1'b0;
    chk("hlt_no_req", 32'(nreq), 32'd0);
    chk("hlt_stays", 32'(st), 32'd5);
    chk("total_done", 32'(ndone - n0), 32'd19);
    #2 rst = 1'b1;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_state", 32'(st), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
